// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - MD_* operation encodings carried on the 3-bit op bus from ID/EX
//   - md_state_t: iterative unit FSM states
//   - MD_ITER: number of iteration cycles for the 32-bit datapath
//   - md_abs32: two's-complement magnitude helper used at operand capture
package mips_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } md_state_t;

    // Magnitude of a signed 32-bit value; 0x80000000 maps onto itself,
    // which is exactly the unsigned magnitude the datapath needs.
    function automatic logic [31:0] md_abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// md_iter_step: one combinational iteration of the multiply/divide datapath.
// Optional feature macro: MULDIV_DIV_EN (restoring-divide step present).
// Ports:
//   acc_i   [63:0]  partial value. Multiply: {partial product, multiplier}.
//                   Divide: {partial remainder, dividend/quotient shift}.
//   opnd_i  [31:0]  multiplicand (multiply) or divisor magnitude (divide)
//   mode_i          0 = shift-add multiply step, 1 = restoring divide step
//   acc_o   [63:0]  next partial value
//   q_bit_o         quotient bit produced by a divide step (0 for multiply)
import mips_pkg::*;

module md_iter_step (
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    input  logic        mode_i,
    output logic [63:0] acc_o,
    output logic        q_bit_o
);

    // Multiply: LSB-first shift-add. The 33-bit sum keeps the carry, which
    // is shifted into bit 63 so nothing of the 64-bit product is lost.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    assign mul_sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    assign mul_next = {mul_sum, acc_i[31:1]};

`ifdef MULDIV_DIV_EN
    // Divide: shift the next dividend bit into the remainder, trial-subtract
    // the divisor, keep the difference only when it did not go negative.
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic        ge;
    logic [63:0] div_next;
    logic        div_bits_unused;

    assign rem_sh   = {acc_i[63:32], acc_i[31]};
    assign diff     = {1'b0, rem_sh} - {2'b00, opnd_i};
    assign ge       = ~diff[33];
    // When ge is set the difference is below the divisor, so 32 bits suffice.
    assign div_next = {(ge ? diff[31:0] : rem_sh[31:0]), acc_i[30:0], ge};
    assign div_bits_unused = diff[32] ^ rem_sh[32];

    always_comb begin
        acc_o   = mode_i ? div_next : mul_next;
        q_bit_o = mode_i & ge;
    end
`else
    logic mode_unused;
    assign mode_unused = mode_i;

    always_comb begin
        acc_o   = mul_next;
        q_bit_o = 1'b0;
    end
`endif

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit for the EX stage.
// Owns the architectural HI/LO registers. Mult/div take 33 busy cycles
// (32 CALC iterations + 1 FIXUP); MTHI/MTLO write in a single edge from IDLE.
// Optional feature macro: MULDIV_DIV_EN (divide support; without it op 2/3
// are ignored and div_by_zero is tied low).
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        ID/EX holds a muldiv op (sampled on the edge)
//   op     [2:0] 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   rs_val [31:0] operand A / MTHI-MTLO data
//   rt_val [31:0] operand B
//   flush        abort in-flight op; also drops a same-cycle start
//   busy         op in progress (hazard unit stalls)
//   done         one-cycle pulse when a mult/div writes HI/LO
//   div_by_zero  one-cycle pulse with done for a divide by zero
//   hi, lo [31:0] HI/LO registers
import mips_pkg::*;

module ex_muldiv_unit #(
    parameter int ITER = MD_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      opnd_q, opnd_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [63:0]      step_acc;
    logic             step_q_bit_unused;
    logic             step_mode;

    logic             start_mul;
    logic             start_div;
    logic             accept;
    logic             signed_op;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic [63:0]      acc_neg;

`ifdef MULDIV_DIV_EN
    logic             mode_q, mode_d;
    logic             dbz_flag_q, dbz_flag_d;
    logic             dbz_q, dbz_d;

    assign start_div = start && !flush && (op == MD_DIV || op == MD_DIVU);
    assign step_mode = mode_q;
`else
    assign start_div = 1'b0;
    assign step_mode = 1'b0;
`endif

    assign start_mul = start && !flush && (op == MD_MULT || op == MD_MULTU);
    assign accept    = (state_q == IDLE) && (start_mul || start_div);
    assign acc_neg   = ~acc_q + 64'd1;

    md_iter_step u_step (
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .mode_i  (step_mode),
        .acc_o   (step_acc),
        .q_bit_o (step_q_bit_unused)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            mode_q     <= 1'b0;
            dbz_flag_q <= 1'b0;
            dbz_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MULDIV_DIV_EN
            mode_q     <= mode_d;
            dbz_flag_q <= dbz_flag_d;
            dbz_q      <= dbz_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC: begin
                if (flush)            state_d = IDLE;
                else if (cnt_q == '0) state_d = FIXUP;
            end
            FIXUP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath / output logic ----------------
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        busy_d    = (state_d != IDLE);
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        a_mag     = signed_op ? md_abs32(rs_val) : rs_val;
        b_mag     = signed_op ? md_abs32(rt_val) : rt_val;
`ifdef MULDIV_DIV_EN
        mode_d     = mode_q;
        dbz_flag_d = dbz_flag_q;
        dbz_d      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start && !flush && op == MD_MTHI) hi_d = rs_val;
                if (start && !flush && op == MD_MTLO) lo_d = rs_val;
                if (accept) begin
                    cnt_d    = CNT_LOAD;
                    sign_a_d = signed_op & rs_val[31];
                    sign_b_d = signed_op & rt_val[31];
                    // Multiply keeps the multiplier in the low half and adds
                    // the multiplicand; divide shifts the dividend out of the
                    // low half while the quotient fills in behind it.
                    acc_d    = {32'd0, b_mag};
                    opnd_d   = a_mag;
`ifdef MULDIV_DIV_EN
                    mode_d     = start_div;
                    dbz_flag_d = start_div && (rt_val == 32'd0);
                    if (start_div) begin
                        acc_d  = {32'd0, a_mag};
                        opnd_d = b_mag;
                    end
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    cnt_d = '0;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIXUP: begin
                if (!flush) begin
                    done_d = 1'b1;
                    {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? acc_neg : acc_q;
`ifdef MULDIV_DIV_EN
                    if (mode_q) begin
                        // Quotient sign follows sA^sB, remainder follows the dividend.
                        lo_d  = (sign_a_q ^ sign_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                        hi_d  = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                        dbz_d = dbz_flag_q;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_DIV_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit. Divide vectors are
// exercised when MULDIV_DIV_EN is defined; otherwise op 2/3 are checked to
// be ignored.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // Issue one op and observe a fixed 40-cycle window (sampled on negedges).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cnt, output int done_cnt, output int dbz_cnt,
                          output int overlap);
        busy_cnt = 0; done_cnt = 0; dbz_cnt = 0; overlap = 0;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (div_by_zero) dbz_cnt++;
            if ((done && busy) || (div_by_zero && !done)) overlap++;
            @(negedge clk);
        end
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d done=%0d dbz=%0d",
                 o, a, b, hi, lo, busy_cnt, done_cnt, dbz_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({hi, lo} !== 64'd0) begin
            failures++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo});
        end
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_by_zero});
        end
        rst = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_multu();
        int bc, dc, zc, ov;
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc, zc, ov);
        checks++;
        if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        checks++;
        if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
        checks++;
        if (bc !== 33) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
        checks++;
        if (dc !== 1) begin failures++; $display("FAIL multu_done_pulses got=%0d exp=1", dc); end
        checks++;
        if (zc !== 0 || ov !== 0) begin failures++; $display("FAIL multu_flags dbz=%0d overlap=%0d exp=0/0", zc, ov); end
    endtask

    task automatic test_mult();
        int bc, dc, zc, ov;
        run_op(3'd0, 32'hFFFFFFFD, 32'd7, bc, dc, zc, ov);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            failures++; $display("FAIL mult_neg got=%h exp=ffffffffffffffeb", {hi, lo});
        end
        checks++;
        if (dc !== 1 || bc !== 33) begin failures++; $display("FAIL mult_timing done=%0d busy=%0d exp=1/33", dc, bc); end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        int bc, dc, zc, ov;
        run_op(3'd3, 32'd100, 32'd7, bc, dc, zc, ov);
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin failures++; $display("FAIL divu_100_7 got=%h exp=%h", {hi, lo}, {32'd2, 32'd14}); end
        checks++;
        if (dc !== 1 || zc !== 0 || bc !== 33) begin failures++; $display("FAIL divu_timing done=%0d dbz=%0d busy=%0d exp=1/0/33", dc, zc, bc); end
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, bc, dc, zc, ov);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin failures++; $display("FAIL div_m7_2 got=%h exp=fffffffffffffffd", {hi, lo}); end
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, bc, dc, zc, ov);
        checks++;
        if ({hi, lo} !== 64'h00000000_80000000) begin failures++; $display("FAIL div_overflow got=%h exp=0000000080000000", {hi, lo}); end
        checks++;
        if (zc !== 0) begin failures++; $display("FAIL div_overflow_dbz got=%0d exp=0", zc); end
        run_op(3'd3, 32'd5, 32'd0, bc, dc, zc, ov);
        checks++;
        if ({hi, lo} !== 64'h00000005_FFFFFFFF) begin failures++; $display("FAIL divu_by_zero got=%h exp=00000005ffffffff", {hi, lo}); end
        checks++;
        if (zc !== 1 || dc !== 1 || ov !== 0) begin
            failures++; $display("FAIL divu_by_zero_pulse dbz=%0d done=%0d misaligned=%0d exp=1/1/0", zc, dc, ov);
        end
    endtask
`else
    task automatic test_div_disabled();
        int bc, dc, zc, ov;
        logic [63:0] prev;
        prev = {hi, lo};
        run_op(3'd2, 32'd100, 32'd7, bc, dc, zc, ov);
        checks++;
        if (bc !== 0 || dc !== 0 || zc !== 0) begin failures++; $display("FAIL div_disabled_flags busy=%0d done=%0d dbz=%0d exp=0/0/0", bc, dc, zc); end
        run_op(3'd3, 32'd5, 32'd0, bc, dc, zc, ov);
        checks++;
        if ({hi, lo} !== prev || bc !== 0 || zc !== 0) begin
            failures++; $display("FAIL divu_disabled got=%h busy=%0d dbz=%0d exp=%h/0/0", {hi, lo}, bc, zc, prev);
        end
    endtask
`endif

    task automatic test_ignored_op();
        int bc, dc, zc, ov;
        logic [63:0] prev;
        prev = {hi, lo};
        run_op(3'd6, 32'h11111111, 32'h22222222, bc, dc, zc, ov);
        checks++;
        if ({hi, lo} !== prev || bc !== 0 || dc !== 0) begin
            failures++; $display("FAIL op6_ignored got=%h busy=%0d done=%0d exp=%h/0/0", {hi, lo}, bc, dc, prev);
        end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        start = 1'b1; op = 3'd4; rs_val = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (hi !== 32'h12345678 || busy !== 1'b0) begin
            failures++; $display("FAIL mthi got hi=%h busy=%b exp=12345678/0", hi, busy);
        end
        start = 1'b1; op = 3'd5; rs_val = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678 || done !== 1'b0) begin
            failures++; $display("FAIL mtlo got hi=%h lo=%h done=%b exp=12345678/9abcdef0/0", hi, lo, done);
        end
        // flush in the same cycle as start drops the write
        start = 1'b1; flush = 1'b1; op = 3'd5; rs_val = 32'hFFFF0000;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++;
        if (lo !== 32'h9ABCDEF0) begin failures++; $display("FAIL mtlo_flushed got lo=%h exp=9abcdef0", lo); end
        $display("mthi/mtlo hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_flush();
        int dc;
        dc = 0;
        @(negedge clk);
        start = 1'b1; op = 3'd4; rs_val = 32'hAAAA0001;
        @(negedge clk);
        op = 3'd5; rs_val = 32'h55550002;
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd5;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start  = (k == 5);
            op     = (k == 5) ? 3'd4 : 3'd0;
            rs_val = (k == 5) ? 32'hDEADBEEF : 32'd3;
            flush  = (k == 10);
            if (k == 11) begin
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
            end
            if (done) dc++;
        end
        checks++;
        if (dc !== 0) begin failures++; $display("FAIL flush_done got=%0d exp=0", dc); end
        checks++;
        if ({hi, lo} !== 64'hAAAA0001_55550002) begin
            failures++; $display("FAIL flush_hilo got=%h exp=aaaa000155550002", {hi, lo});
        end
        $display("flush mid-MULT hi=%h lo=%h done_pulses=%0d", hi, lo, dc);
    endtask

    task automatic test_back_to_back();
        int bc, dc, zc, ov;
        int waited;
        waited = 0;
        @(negedge clk);
        start = 1'b1; op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        while (!done && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!done) begin failures++; $display("FAIL b2b_first_done got=timeout exp=pulse"); end
        checks++;
        if ({hi, lo} !== 64'd6) begin failures++; $display("FAIL b2b_first got=%h exp=6", {hi, lo}); end
        $display("b2b first MULTU 2*3 hi=%h lo=%h", hi, lo);
        // issue the next op in the done cycle; it is accepted on the following edge
        start = 1'b1; op = 3'd0; rs_val = 32'hFFFFFFFF; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
        bc = 0; dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            if (done) dc++;
            @(negedge clk);
        end
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFB || dc !== 1 || bc !== 33) begin
            failures++; $display("FAIL b2b_second got=%h done=%0d busy=%0d exp=fffffffffffffffb/1/33", {hi, lo}, dc, bc);
        end
        $display("b2b second MULT -1*5 hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
`ifdef MULDIV_DIV_EN
        op = 3'd2;
`else
        op = 3'd1;
`endif
        rs_val = 32'd1000; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || {hi, lo} === 64'd0) begin
            failures++; $display("FAIL reset_mid_pre busy=%b hilo=%h exp=1/nonzero", busy, {hi, lo});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({hi, lo} !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_mid got hilo=%h busy=%b done=%b exp=0/0/0", {hi, lo}, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        $display("reset mid-op hi=%h lo=%h busy=%b", hi, lo, busy);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_ignored_op();
        test_mthi_mtlo();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. It is fed directly by the ID/EX pipeline register, taking its operands after the forwarding muxes, and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It owns the architectural HI/LO registers and drives a `busy` signal that the hazard unit uses to stall IF/ID/EX while an operation is in flight. MFHI and MFLO read the `hi`/`lo` outputs directly.

## Interface
Parameters:
- `ITER`, default 32: number of iteration cycles; fixed at 32 for a 32-bit datapath.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: ID/EX holds a mult/div/mthi/mtlo op; sampled on the rising edge.
- `op`, in, 3: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are ignored.
- `rs_val`, in, 32: operand A (multiplicand/dividend, or the MTHI/MTLO data), post-forwarding.
- `rt_val`, in, 32: operand B (multiplier/divisor).
- `flush`, in, 1: abort any in-flight op (branch squash or exception).
- `busy`, out, 1: an operation is in progress; the hazard unit stalls while this is high.
- `done`, out, 1: one-cycle pulse when HI/LO are updated by a mult/div.
- `div_by_zero`, out, 1: one-cycle pulse coincident with `done` for DIV/DIVU with `rt_val`=0.
- `hi`, out, 32: HI register.
- `lo`, out, 32: LO register.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, state=IDLE, iteration counter=0.
- States:
  - IDLE → CALC on `start`, when `op` is 0–3 and `flush`=0.
  - CALC → CALC while counter≠0. Each cycle performs one shift-add (multiply) or one restoring subtract (divide) step and decrements the counter.
  - CALC → FIXUP when counter=0.
  - FIXUP → IDLE: applies sign correction, writes HI/LO, and pulses `done`.
- Operand capture on start:
  - For signed ops, latch magnitudes |A| and |B|, plus the sign flags sA and sB.
  - For unsigned ops, latch the raw values with both sign flags at 0.
- Multiply: the 64-bit magnitude product is negated if sA^sB. HI receives bits [63:32] and LO bits [31:0].
- Divide: quotient magnitude goes to LO and remainder magnitude to HI.
  - LO is negated if sA^sB.
  - HI is negated if sA.
  - Remainder takes the sign of the dividend.
- Divide by zero takes the normal datapath with no special case. Results: LO=0xFFFFFFFF and HI=|A| (re-signed by sA for DIV). `div_by_zero` pulses.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural wrap result and raises no flag.
- MTHI/MTLO in IDLE: write `rs_val` to `hi`/`lo` at the sampling edge. `busy` stays 0 and `done` does not pulse.
- `start` while `busy`=1 is ignored. The hazard unit guarantees it holds the instruction.
- `flush` in CALC or FIXUP: state goes to IDLE on the next edge, HI/LO are unchanged, and neither `done` nor `div_by_zero` pulses.
- `flush` together with `start` in IDLE: flush wins and the op is dropped, including MTHI/MTLO.
- `rst` asserted mid-operation: all state and outputs clear immediately to their reset values.

## Timing
- `start` is accepted at edge E0.
- `busy` is high from after E0 until E33, which is 33 cycles.
- CALC runs on edges E1–E32. FIXUP writes HI/LO at E33.
- `done` and `div_by_zero` are high for the cycle following E33. `busy` is 0 in that same cycle.
- A new `start` may therefore be accepted at E33+1 edge, i.e. back-to-back ops cost 34 cycles.
- MTHI/MTLO take effect at E0, with `hi`/`lo` visible after E0 (zero stall).
- All outputs are registered. There is no combinational path from the inputs to any output.

## Configuration
- `MULDIV_DIV_EN` defined: the full unit as specified above.
- `MULDIV_DIV_EN` undefined:
  - The divide datapath is removed.
  - `op` 2/3 are treated as ignored opcodes: no state change, `busy` stays 0, HI/LO unchanged.
  - `div_by_zero` is tied to 0.
  - Multiply and MTHI/MTLO behaviour and timing are unchanged.

## Structure
- Shared package `mips_pkg` holds:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`;
  - the state enum `md_state_t` (IDLE/CALC/FIXUP);
  - constant `MD_ITER`=32.
- One sub-module, `md_iter_step`: a combinational single iteration. Inputs are the partial remainder/product and a mode bit. Outputs are the next partial value and the quotient bit.
- The top level holds the FSM, counter, operand/sign registers, fixup and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `busy` is high for exactly 33 cycles and `done` pulses once.
- MULT −3×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIVU 100/7 → LO=14, HI=2.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5, with `div_by_zero` and `done` pulsing in the same cycle.
- MULT with `flush` at cycle 10 of CALC → `busy`=0 the next cycle, HI/LO hold their prior values, no `done`. A `start` issued while busy is ignored.
- MTHI 0x12345678 → `hi`=0x12345678 after one edge with `busy`=0. Asserting `rst` low mid-DIV → `hi`, `lo`, `busy` and `done` read 0 immediately.
